cmd_exec_dispatch: RTL and testbench

Command execution stage in the dst_clk domain, fed directly by the command bus synchronizer's dst_cmd/dst_req/dst_ack outputs. Accepts synchronized commands over a four-phase req/ack handshake and buffers them in a small FIFO. Decodes each entry into NOP/WRITE/READ and issues it on a valid/ready register bus. READ data is returned on a response channel.

---
 rtl/cmd_exec_dispatch.sv | 257 +++++++++++++++++++++++++
 tb/tb_cmd_exec_dispatch.sv | 520 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_exec_dispatch.sv
// -----------------------------------------------------------------------------
// cmd_exec_dispatch
//
// Command execution stage in the dst_clk domain. Commands arrive from the
// command bus synchronizer over a four-phase req/ack handshake and are queued
// in a small FIFO. A dispatcher pops them in order, drops NOP and reserved
// entries, and issues WRITE/READ on a valid/ready register bus. READ data is
// returned on a valid/ready response channel.
//
// Build option:
//   CMD_EXEC_ERR_EN  when defined, a popped reserved opcode sets the sticky
//                    err_flag and increments the saturating err_cnt. When
//                    undefined, reserved opcodes behave as NOP and the error
//                    outputs are constant 0.
//
// Ports:
//   dst_clk     in   block clock
//   dst_rst     in   asynchronous active-low reset
//   cmd_in      in   command word {opcode[1:0], addr[ADDR_W-1:0], data[DATA_W-1:0]}
//   cmd_req     in   level request, cmd_in stable while high
//   cmd_ack     out  level acknowledge (four-phase)
//   bus_valid   out  register bus request
//   bus_we      out  1 = write, 0 = read
//   bus_addr    out  register address
//   bus_wdata   out  write data
//   bus_ready   in   bus accepts; bus_rdata valid in the same cycle for reads
//   bus_rdata   in   read data
//   rsp_valid   out  read response valid
//   rsp_addr    out  address of the response
//   rsp_data    out  read data
//   rsp_ready   in   response consumer ready
//   fifo_level  out  current FIFO occupancy
//   err_flag    out  sticky reserved-opcode flag
//   err_cnt     out  saturating reserved-opcode count
//   err_clr     in   clears err_flag and err_cnt
//
// CMD_WIDTH must equal 2 + ADDR_W + DATA_W; FIFO_DEPTH must be a power of
// two and at least 2 so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module cmd_exec_dispatch #(
    parameter int CMD_WIDTH  = 16,
    parameter int ADDR_W     = 6,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          dst_clk,
    input  logic                          dst_rst,
    input  logic [CMD_WIDTH-1:0]          cmd_in,
    input  logic                          cmd_req,
    output logic                          cmd_ack,
    output logic                          bus_valid,
    output logic                          bus_we,
    output logic [ADDR_W-1:0]             bus_addr,
    output logic [DATA_W-1:0]             bus_wdata,
    input  logic                          bus_ready,
    input  logic [DATA_W-1:0]             bus_rdata,
    output logic                          rsp_valid,
    output logic [ADDR_W-1:0]             rsp_addr,
    output logic [DATA_W-1:0]             rsp_data,
    input  logic                          rsp_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          err_flag,
    output logic [7:0]                    err_cnt,
    input  logic                          err_clr
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OP_NOP   = 2'b00,
        OP_WRITE = 2'b01,
        OP_READ  = 2'b10,
        OP_RSVD  = 2'b11
    } op_t;

    // ------------------------------------------------------------------
    // Command FIFO
    // ------------------------------------------------------------------
    logic [CMD_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     r_wr_ptr;
    logic [PTR_W-1:0]     r_rd_ptr;
    logic [LVL_W-1:0]     r_level;
    logic                 r_ack;
    state_t               r_state;

    logic                 w_full;
    logic                 w_empty;
    logic                 w_push;
    logic                 w_pop;
    logic [CMD_WIDTH-1:0] w_head;
    op_t                  w_head_op;

    assign w_full    = (r_level == LVL_W'(FIFO_DEPTH));
    assign w_empty   = (r_level == '0);
    // A new word is taken only on the rising phase of the handshake (ack
    // still low), which limits capture to one push per four-phase cycle.
    assign w_push    = cmd_req && !r_ack && !w_full;
    // The dispatcher consumes one entry per cycle while idle; NOP and
    // reserved entries are simply dropped on the pop.
    assign w_pop     = (r_state == S_IDLE) && !w_empty;
    assign w_head    = r_mem[r_rd_ptr];
    assign w_head_op = op_t'(w_head[CMD_WIDTH-1 -: 2]);

    // NOTE: storage array has no reset; validity is tracked by the pointers
    // and level, so clearing the data would only cost reset fan-out.
    always_ff @(posedge dst_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= cmd_in;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // sees the pre-edge values of the others regardless of statement order.
    always_ff @(posedge dst_clk or negedge dst_rst) begin
        if (!dst_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // Four-phase acknowledge: set on capture, held while req stays high,
    // dropped on the edge after req is seen low.
    always_ff @(posedge dst_clk or negedge dst_rst) begin
        if (!dst_rst) begin
            r_ack <= 1'b0;
        end else if (!cmd_req) begin
            r_ack <= 1'b0;
        end else if (w_push) begin
            r_ack <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Dispatcher FSM with registered bus and response outputs
    // ------------------------------------------------------------------
    logic              r_bus_valid;
    logic              r_bus_we;
    logic [ADDR_W-1:0] r_bus_addr;
    logic [DATA_W-1:0] r_bus_wdata;
    logic              r_rsp_valid;
    logic [ADDR_W-1:0] r_rsp_addr;
    logic [DATA_W-1:0] r_rsp_data;

    always_ff @(posedge dst_clk or negedge dst_rst) begin
        if (!dst_rst) begin
            r_state     <= S_IDLE;
            r_bus_valid <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= '0;
            r_bus_wdata <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_addr  <= '0;
            r_rsp_data  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pop && (w_head_op == OP_WRITE || w_head_op == OP_READ)) begin
                        r_bus_valid <= 1'b1;
                        r_bus_we    <= (w_head_op == OP_WRITE);
                        r_bus_addr  <= w_head[ADDR_W+DATA_W-1 -: ADDR_W];
                        r_bus_wdata <= w_head[DATA_W-1:0];
                        r_state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (bus_ready) begin
                        r_bus_valid <= 1'b0;
                        if (r_bus_we) begin
                            r_state <= S_IDLE;
                        end else begin
                            // Read data is only valid while bus_ready is high,
                            // so it is captured on the accepting edge.
                            r_rsp_valid <= 1'b1;
                            r_rsp_addr  <= r_bus_addr;
                            r_rsp_data  <= bus_rdata;
                            r_state     <= S_RESP;
                        end
                    end
                end
                S_RESP: begin
                    // No pop happens here, so a read completes before the
                    // next command leaves the FIFO.
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign cmd_ack    = r_ack;
    assign fifo_level = r_level;
    assign bus_valid  = r_bus_valid;
    assign bus_we     = r_bus_we;
    assign bus_addr   = r_bus_addr;
    assign bus_wdata  = r_bus_wdata;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_addr   = r_rsp_addr;
    assign rsp_data   = r_rsp_data;

    // ------------------------------------------------------------------
    // Reserved-opcode error tracking
    // ------------------------------------------------------------------
`ifdef CMD_EXEC_ERR_EN
    logic       r_err_flag;
    logic [7:0] r_err_cnt;

    // Clear has priority over a coincident reserved pop.
    always_ff @(posedge dst_clk or negedge dst_rst) begin
        if (!dst_rst) begin
            r_err_flag <= 1'b0;
            r_err_cnt  <= 8'd0;
        end else if (err_clr) begin
            r_err_flag <= 1'b0;
            r_err_cnt  <= 8'd0;
        end else if (w_pop && w_head_op == OP_RSVD) begin
            r_err_flag <= 1'b1;
            if (r_err_cnt != 8'hFF) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end
        end
    end

    assign err_flag = r_err_flag;
    assign err_cnt  = r_err_cnt;
`else
    // Error tracking is compiled out: outputs are tied low and err_clr has
    // no effect (the AND keeps the input connected to a load).
    assign err_flag = 1'b0 & err_clr;
    assign err_cnt  = 8'd0;
`endif

endmodule

// File: tb/tb_cmd_exec_dispatch.sv
// -----------------------------------------------------------------------------
// tb_cmd_exec_dispatch
//
// Self-checking bench for cmd_exec_dispatch. Directed scenarios cover reset,
// handshake timing, backpressure, FIFO full, back-to-back issue, NOP/reserved
// filtering, error clear and reset mid-transaction; a randomized run compares
// bus and response traffic against an in-order transaction model built from
// the command list. Inputs are driven and outputs sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_cmd_exec_dispatch;

    localparam int CW    = 16;
    localparam int AW    = 6;
    localparam int DW    = 8;
    localparam int DEPTH = 4;

`ifdef CMD_EXEC_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } xfer_t;

    logic          dst_clk   = 1'b0;
    logic          dst_rst   = 1'b0;
    logic [CW-1:0] cmd_in    = '0;
    logic          cmd_req   = 1'b0;
    logic          cmd_ack;
    logic          bus_valid;
    logic          bus_we;
    logic [AW-1:0] bus_addr;
    logic [DW-1:0] bus_wdata;
    logic          bus_ready = 1'b0;
    logic [DW-1:0] bus_rdata = '0;
    logic          rsp_valid;
    logic [AW-1:0] rsp_addr;
    logic [DW-1:0] rsp_data;
    logic          rsp_ready = 1'b0;
    logic [2:0]    fifo_level;
    logic          err_flag;
    logic [7:0]    err_cnt;
    logic          err_clr   = 1'b0;

    logic [43:0]   all_outs;
    assign all_outs = {bus_valid, bus_we, bus_addr, bus_wdata, rsp_valid, rsp_addr,
                       rsp_data, cmd_ack, fifo_level, err_flag, err_cnt};

    int n_vec = 0;
    int n_err = 0;

    cmd_exec_dispatch #(
        .CMD_WIDTH (CW),
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .dst_clk   (dst_clk),
        .dst_rst   (dst_rst),
        .cmd_in    (cmd_in),
        .cmd_req   (cmd_req),
        .cmd_ack   (cmd_ack),
        .bus_valid (bus_valid),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_ready (bus_ready),
        .bus_rdata (bus_rdata),
        .rsp_valid (rsp_valid),
        .rsp_addr  (rsp_addr),
        .rsp_data  (rsp_data),
        .rsp_ready (rsp_ready),
        .fifo_level(fifo_level),
        .err_flag  (err_flag),
        .err_cnt   (err_cnt),
        .err_clr   (err_clr)
    );

    always #5 dst_clk = ~dst_clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Complete four-phase handshake for one command, bounded on both phases.
    task automatic push_cmd(input logic [CW-1:0] c);
        int t;
        cmd_in  = c;
        cmd_req = 1'b1;
        t = 0;
        @(negedge dst_clk);
        while (!cmd_ack && t < 200) begin
            @(negedge dst_clk);
            t++;
        end
        n_vec++;
        if (cmd_ack !== 1'b1) begin
            n_err++;
            $display("FAIL push_ack cmd=%h: got ack=%b want 1", c, cmd_ack);
        end
        cmd_req = 1'b0;
        t = 0;
        @(negedge dst_clk);
        while (cmd_ack && t < 200) begin
            @(negedge dst_clk);
            t++;
        end
        n_vec++;
        if (cmd_ack !== 1'b0) begin
            n_err++;
            $display("FAIL push_release cmd=%h: got ack=%b want 0", c, cmd_ack);
        end
    endtask

    task automatic test_reset();
        dst_rst = 1'b0;
        repeat (3) @(negedge dst_clk);
        n_vec++;
        if (all_outs !== '0) begin
            n_err++;
            $display("FAIL reset_outs: got %h want 0", all_outs);
        end
        dst_rst = 1'b1;
        repeat (2) @(negedge dst_clk);
        n_vec++;
        if (all_outs !== '0) begin
            n_err++;
            $display("FAIL post_reset_idle: got %h want 0", all_outs);
        end
    endtask

    task automatic test_single_write();
        int n_valid;
        bus_ready = 1'b1;
        cmd_in    = 16'h4A5C;
        cmd_req   = 1'b1;
        @(negedge dst_clk);
        n_vec++;
        if ({cmd_ack, bus_valid} !== 2'b10) begin
            n_err++;
            $display("FAIL sw_ack_rise: got ack,valid=%b want 10", {cmd_ack, bus_valid});
        end
        @(negedge dst_clk);
        n_vec++;
        if ({bus_valid, bus_we, bus_addr, bus_wdata, cmd_ack} !== {1'b1, 1'b1, 6'h0A, 8'h5C, 1'b1}) begin
            n_err++;
            $display("FAIL sw_issue: got v=%b we=%b a=%h d=%h ack=%b want 1 1 0a 5c 1",
                     bus_valid, bus_we, bus_addr, bus_wdata, cmd_ack);
        end
        cmd_req = 1'b0;
        @(negedge dst_clk);
        n_vec++;
        if ({bus_valid, cmd_ack} !== 2'b00) begin
            n_err++;
            $display("FAIL sw_done: got valid,ack=%b want 00", {bus_valid, cmd_ack});
        end
        n_valid = 0;
        repeat (4) begin
            @(negedge dst_clk);
            if (bus_valid) n_valid++;
        end
        n_vec++;
        if (n_valid != 0) begin
            n_err++;
            $display("FAIL sw_single_cycle: got %0d extra valid cycles want 0", n_valid);
        end
        bus_ready = 1'b0;
    endtask

    task automatic test_read_backpressure();
        bus_ready = 1'b0;
        rsp_ready = 1'b0;
        cmd_in    = 16'h8300;
        cmd_req   = 1'b1;
        @(negedge dst_clk);
        cmd_req = 1'b0;
        @(negedge dst_clk);
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if ({bus_valid, bus_we, bus_addr} !== {1'b1, 1'b0, 6'h03}) begin
                n_err++;
                $display("FAIL rd_hold[%0d]: got v=%b we=%b a=%h want 1 0 03", i, bus_valid, bus_we, bus_addr);
            end
            if (i == 3) begin
                bus_ready = 1'b1;
                bus_rdata = 8'hA7;
            end
            @(negedge dst_clk);
        end
        bus_ready = 1'b0;
        bus_rdata = 8'h00;
        n_vec++;
        if (bus_valid !== 1'b0) begin
            n_err++;
            $display("FAIL rd_valid_drop: got %b want 0", bus_valid);
        end
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            if ({rsp_valid, rsp_addr, rsp_data} !== {1'b1, 6'h03, 8'hA7}) begin
                n_err++;
                $display("FAIL rd_rsp[%0d]: got v=%b a=%h d=%h want 1 03 a7", i, rsp_valid, rsp_addr, rsp_data);
            end
            if (i == 2) rsp_ready = 1'b1;
            @(negedge dst_clk);
        end
        rsp_ready = 1'b0;
        n_vec++;
        if (rsp_valid !== 1'b0) begin
            n_err++;
            $display("FAIL rd_rsp_drop: got %b want 0", rsp_valid);
        end
    endtask

    // One write is held on the bus while four more fill the FIFO; the next
    // request must then wait until the bus drains one entry.
    task automatic test_fifo_full();
        logic [CW-1:0] cmds [6];
        int k;
        int t;
        for (int i = 0; i < 6; i++) cmds[i] = {2'b01, 6'($urandom), 8'($urandom)};
        bus_ready = 1'b0;
        for (int i = 0; i < 5; i++) push_cmd(cmds[i]);
        n_vec++;
        if ({fifo_level, bus_valid, bus_addr} !== {3'd4, 1'b1, cmds[0][13:8]}) begin
            n_err++;
            $display("FAIL full_level: got lvl=%0d v=%b a=%h want 4 1 %h", fifo_level, bus_valid, bus_addr, cmds[0][13:8]);
        end
        cmd_in  = cmds[5];
        cmd_req = 1'b1;
        repeat (4) begin
            @(negedge dst_clk);
            n_vec++;
            if ({cmd_ack, fifo_level} !== {1'b0, 3'd4}) begin
                n_err++;
                $display("FAIL full_wait: got ack=%b lvl=%0d want 0 4", cmd_ack, fifo_level);
            end
        end
        bus_ready = 1'b1;
        n_vec++;
        if ({bus_we, bus_addr, bus_wdata} !== {1'b1, cmds[0][13:0]}) begin
            n_err++;
            $display("FAIL full_first: got we=%b a=%h d=%h want 1 %h %h", bus_we, bus_addr, bus_wdata, cmds[0][13:8], cmds[0][7:0]);
        end
        @(negedge dst_clk);
        bus_ready = 1'b0;
        t = 0;
        while (!cmd_ack && t < 20) begin
            @(negedge dst_clk);
            t++;
        end
        n_vec++;
        if (cmd_ack !== 1'b1) begin
            n_err++;
            $display("FAIL full_capture: got ack=%b want 1", cmd_ack);
        end
        cmd_req   = 1'b0;
        bus_ready = 1'b1;
        k = 1;
        t = 0;
        while (k < 6 && t < 60) begin
            if (bus_valid) begin
                n_vec++;
                if ({bus_we, bus_addr, bus_wdata} !== {1'b1, cmds[k][13:0]}) begin
                    n_err++;
                    $display("FAIL full_order[%0d]: got a=%h d=%h want %h %h", k, bus_addr, bus_wdata, cmds[k][13:8], cmds[k][7:0]);
                end
                k++;
            end
            @(negedge dst_clk);
            t++;
        end
        repeat (2) @(negedge dst_clk);
        n_vec++;
        if (k != 6 || fifo_level !== 3'd0) begin
            n_err++;
            $display("FAIL full_drain: got %0d issued lvl=%0d want 6 0", k, fifo_level);
        end
        bus_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        int times [$];
        bus_ready = 1'b0;
        for (int i = 0; i < 4; i++) push_cmd({2'b01, 6'(i + 8), 8'($urandom)});
        bus_ready = 1'b1;
        for (int t = 0; t < 20; t++) begin
            if (bus_valid) times.push_back(t);
            @(negedge dst_clk);
        end
        bus_ready = 1'b0;
        n_vec++;
        if (times.size() != 4) begin
            n_err++;
            $display("FAIL b2b_count: got %0d transfers want 4", times.size());
        end else begin
            for (int i = 1; i < 4; i++) begin
                n_vec++;
                if (times[i] - times[i-1] != 2) begin
                    n_err++;
                    $display("FAIL b2b_spacing[%0d]: got %0d cycles want 2", i, times[i] - times[i-1]);
                end
            end
        end
    endtask

    task automatic test_nop_stream();
        int n_wr;
        bus_ready = 1'b0;
        push_cmd(16'h0000);
        push_cmd(16'hC0FF);
        push_cmd(16'h4101);
        bus_ready = 1'b1;
        n_wr = 0;
        repeat (10) begin
            if (bus_valid) begin
                n_wr++;
                n_vec++;
                if ({bus_we, bus_addr, bus_wdata} !== {1'b1, 6'h01, 8'h01}) begin
                    n_err++;
                    $display("FAIL nop_write: got we=%b a=%h d=%h want 1 01 01", bus_we, bus_addr, bus_wdata);
                end
            end
            @(negedge dst_clk);
        end
        bus_ready = 1'b0;
        n_vec++;
        if (n_wr != 1) begin
            n_err++;
            $display("FAIL nop_count: got %0d writes want 1", n_wr);
        end
        n_vec++;
        if ({err_flag, err_cnt} !== {ERR_EN, 8'(ERR_EN)}) begin
            n_err++;
            $display("FAIL nop_err: got flag=%b cnt=%0d want %b %0d", err_flag, err_cnt, ERR_EN, ERR_EN);
        end
    endtask

    task automatic test_err_clr();
        // Reserved entry pops at the end of the cycle after capture; raise
        // err_clr for exactly that cycle.
        cmd_in  = 16'hC000;
        cmd_req = 1'b1;
        @(negedge dst_clk);
        err_clr = 1'b1;
        @(negedge dst_clk);
        err_clr = 1'b0;
        cmd_req = 1'b0;
        n_vec++;
        if ({err_flag, err_cnt} !== 9'd0) begin
            n_err++;
            $display("FAIL clr_coincide: got flag=%b cnt=%0d want 0 0", err_flag, err_cnt);
        end
        repeat (2) @(negedge dst_clk);
        for (int i = 0; i < 257; i++) push_cmd({2'b11, 14'($urandom)});
        repeat (2) @(negedge dst_clk);
        n_vec++;
        if ({err_flag, err_cnt} !== {ERR_EN, (ERR_EN ? 8'd255 : 8'd0)}) begin
            n_err++;
            $display("FAIL err_saturate: got flag=%b cnt=%0d want %b %0d", err_flag, err_cnt, ERR_EN, ERR_EN ? 255 : 0);
        end
        err_clr = 1'b1;
        @(negedge dst_clk);
        err_clr = 1'b0;
        n_vec++;
        if ({err_flag, err_cnt} !== 9'd0) begin
            n_err++;
            $display("FAIL err_clear: got flag=%b cnt=%0d want 0 0", err_flag, err_cnt);
        end
    endtask

    task automatic test_reset_mid_read();
        int n_act;
        bus_ready = 1'b0;
        push_cmd(16'h8305);
        push_cmd(16'h4111);
        push_cmd(16'h8222);
        n_vec++;
        if ({bus_valid, bus_we, fifo_level} !== {1'b1, 1'b0, 3'd2}) begin
            n_err++;
            $display("FAIL mid_setup: got v=%b we=%b lvl=%0d want 1 0 2", bus_valid, bus_we, fifo_level);
        end
        cmd_in  = 16'h4333;
        cmd_req = 1'b1;
        @(negedge dst_clk);
        #1;
        dst_rst = 1'b0;
        #1;
        n_vec++;
        if (all_outs !== '0) begin
            n_err++;
            $display("FAIL mid_reset_async: got %h want 0", all_outs);
        end
        cmd_req = 1'b0;
        @(negedge dst_clk);
        dst_rst   = 1'b1;
        bus_ready = 1'b1;
        rsp_ready = 1'b1;
        n_act = 0;
        repeat (12) begin
            @(negedge dst_clk);
            if (bus_valid || rsp_valid || fifo_level != 0) n_act++;
        end
        bus_ready = 1'b0;
        rsp_ready = 1'b0;
        n_vec++;
        if (n_act != 0) begin
            n_err++;
            $display("FAIL mid_stale: got %0d active cycles want 0", n_act);
        end
    endtask

    // Random commands, random bus/response backpressure; the model is the
    // ordered list of bus transfers and read responses implied by the opcodes.
    task automatic test_random();
        logic [CW-1:0] cmds [$];
        xfer_t         exp_bus [$];
        xfer_t         exp_rsp [$];
        xfer_t         e;
        int            n_rsvd;
        bit            prod_done;
        int            cyc;
        logic [CW-1:0] c;

        err_clr = 1'b1;
        @(negedge dst_clk);
        err_clr = 1'b0;
        n_rsvd    = 0;
        prod_done = 1'b0;
        for (int i = 0; i < 48; i++) begin
            c = 16'($urandom);
            cmds.push_back(c);
            case (c[15:14])
                2'b01:   exp_bus.push_back({1'b1, c[13:8], c[7:0]});
                2'b10:   exp_bus.push_back({1'b0, c[13:8], 8'h00});
                2'b11:   n_rsvd++;
                default: ;
            endcase
        end
        cyc = 0;
        fork
            begin
                foreach (cmds[i]) begin
                    repeat ($urandom_range(0, 2)) @(negedge dst_clk);
                    push_cmd(cmds[i]);
                end
                prod_done = 1'b1;
            end
            begin
                while (!(prod_done && exp_bus.size() == 0 && exp_rsp.size() == 0) && cyc < 4000) begin
                    bus_ready = 1'($urandom_range(0, 1));
                    rsp_ready = 1'($urandom_range(0, 1));
                    bus_rdata = 8'($urandom);
                    if (bus_valid && bus_ready) begin
                        n_vec++;
                        if (exp_bus.size() == 0) begin
                            n_err++;
                            $display("FAIL rnd_bus_extra: got a=%h with no transfer expected", bus_addr);
                        end else begin
                            e = exp_bus.pop_front();
                            if (bus_we !== e.we || bus_addr !== e.addr || (e.we && bus_wdata !== e.data)) begin
                                n_err++;
                                $display("FAIL rnd_bus: got we=%b a=%h d=%h want we=%b a=%h d=%h",
                                         bus_we, bus_addr, bus_wdata, e.we, e.addr, e.data);
                            end
                            if (!e.we) exp_rsp.push_back({1'b0, e.addr, bus_rdata});
                        end
                    end
                    if (rsp_valid && rsp_ready) begin
                        n_vec++;
                        if (exp_rsp.size() == 0) begin
                            n_err++;
                            $display("FAIL rnd_rsp_extra: got a=%h d=%h with none expected", rsp_addr, rsp_data);
                        end else begin
                            e = exp_rsp.pop_front();
                            if (rsp_addr !== e.addr || rsp_data !== e.data) begin
                                n_err++;
                                $display("FAIL rnd_rsp: got a=%h d=%h want a=%h d=%h", rsp_addr, rsp_data, e.addr, e.data);
                            end
                        end
                    end
                    @(negedge dst_clk);
                    cyc++;
                end
            end
        join
        bus_ready = 1'b0;
        rsp_ready = 1'b0;
        n_vec++;
        if (cyc >= 4000 || fifo_level !== 3'd0) begin
            n_err++;
            $display("FAIL rnd_complete: got cycles=%0d lvl=%0d pending=%0d want completion", cyc, fifo_level, exp_bus.size() + exp_rsp.size());
        end
        n_vec++;
        if ({err_flag, err_cnt} !== {ERR_EN && n_rsvd > 0, (ERR_EN ? 8'((n_rsvd > 255) ? 255 : n_rsvd) : 8'd0)}) begin
            n_err++;
            $display("FAIL rnd_err: got flag=%b cnt=%0d reserved=%0d err_en=%b", err_flag, err_cnt, n_rsvd, ERR_EN);
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_read_backpressure();
        test_fifo_full();
        test_back_to_back();
        test_nop_stream();
        test_err_clr();
        test_reset_mid_read();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
